core_lsu: RTL

Load/store unit in the execution/memory boundary of the RV32I core. It consumes the ALU sum (rs1 + imm) as the effective address and rs2 as store data. It runs one aligned data-memory transaction over a req/gnt/rvalid bus and returns a sign- or zero-extended load result to writeback. Misaligned accesses and illegal funct3 codes are flagged without touching memory.

---
 rtl/core_lsu.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/core_lsu.sv
// RV32I load/store unit: one aligned data-memory access per request over a
// req/gnt/rvalid bus. Misaligned or illegal accesses complete with an error
// and never reach the bus.
module core_lsu #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned HALF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state;
    logic [2:0]              funct3_q;
    logic [1:0]              off_q;

    logic                    legal_c;
    logic                    aligned_c;
    logic [3:0]              be_c;
    logic [DATA_WIDTH-1:0]   wdata_c;
    logic [DATA_WIDTH-1:0]   shifted_c;
    logic [DATA_WIDTH-1:0]   load_c;

    // Request decode: legality, alignment, lane enables and replicated store data
    always_comb begin
        legal_c   = 1'b0;
        aligned_c = 1'b1;
        be_c      = 4'b0000;
        wdata_c   = wdata_i;

        case (funct3_i)
            3'b000, 3'b001, 3'b010: legal_c = 1'b1;
            3'b100, 3'b101:         legal_c = ~we_i;
            default:                legal_c = 1'b0;
        endcase

        case (funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_i[1:0];
                wdata_c = {4{wdata_i[BYTE_WIDTH-1:0]}};
            end
            2'b01: begin
                aligned_c = ~addr_i[0];
                be_c      = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c   = {2{wdata_i[HALF_WIDTH-1:0]}};
            end
            default: begin
                aligned_c = (addr_i[1:0] == 2'b00);
                be_c      = 4'b1111;
                wdata_c   = wdata_i;
            end
        endcase
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend
    always_comb begin
        shifted_c = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_c = {{(DATA_WIDTH-BYTE_WIDTH){shifted_c[BYTE_WIDTH-1]}}, shifted_c[BYTE_WIDTH-1:0]};
            3'b001:  load_c = {{(DATA_WIDTH-HALF_WIDTH){shifted_c[HALF_WIDTH-1]}}, shifted_c[HALF_WIDTH-1:0]};
            3'b100:  load_c = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, shifted_c[BYTE_WIDTH-1:0]};
            3'b101:  load_c = {{(DATA_WIDTH-HALF_WIDTH){1'b0}}, shifted_c[HALF_WIDTH-1:0]};
            default: load_c = shifted_c;
        endcase
    end

    // Access sequencer: state plus all registered bus and result outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rdata_o     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        funct3_q <= funct3_i;
                        off_q    <= addr_i[1:0];
                        if (legal_c && aligned_c) begin
                            state       <= REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= we_i;
                            mem_be_o    <= be_c;
                            mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_o <= wdata_c;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_o <= load_c;
                        state   <= DONE;
                        done_o  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Busy flag decoded straight from the state
    assign busy_o = (state != IDLE);

endmodule
